// File: rtl/key_sender_pkg.sv
// rtl/key_sender_pkg.sv - shared types, 7-segment patterns and width helper for the key sender
package key_sender_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_WAIT_RESP,
        ST_DONE
    } state_t;

    // Active-low gfedcba patterns, indexed by hex digit 0..F
    localparam logic [0:15][6:0] SEG7_TABLE = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((32'd1 << width) < value) width = width + 1;
        return width;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - 4-bit to active-low 7-segment decoder
module hex_to_seg7
    import key_sender_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG7_TABLE[digit];

endmodule

// File: rtl/fsm_key_sender.sv
// rtl/fsm_key_sender.sv - replays a stored code as timed b0/b1 presses and reports unlock pass/fail
// Optional abort input enabled by defining KEY_SENDER_ABORT_EN.
module fsm_key_sender
    import key_sender_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int PRESS_CYCLES   = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset_in,
    input  logic                start_in,
    input  logic [CODE_LEN-1:0] code_in,
    input  logic                unlock_in,
`ifdef KEY_SENDER_ABORT_EN
    input  logic                abort_in,
`endif
    output logic                b0_out,
    output logic                b1_out,
    output logic                busy_out,
    output logic                done_out,
    output logic                pass_out,
    output logic [6:0]          hex_display
);

    localparam int SPAN_PG  = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int MAX_SPAN = (SPAN_PG > TIMEOUT_CYCLES) ? SPAN_PG : TIMEOUT_CYCLES;
    localparam int TW       = clog2_min1(MAX_SPAN);

    localparam logic [TW-1:0] PRESS_LAST   = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LEN          = 4'(CODE_LEN);

    state_t              state;
    logic [TW-1:0]       timer;
    logic [CODE_LEN-1:0] code_reg;
    logic [3:0]          count;
    logic [6:0]          next_seg;
    logic                abort_req;

    // Decodes the count the display will show once the current press completes
    hex_to_seg7 u_seg (
        .digit (count + 4'd1),
        .seg   (next_seg)
    );

`ifdef KEY_SENDER_ABORT_EN
    assign abort_req = abort_in &&
                       (state == ST_PRESS || state == ST_GAP || state == ST_WAIT_RESP);
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state       <= ST_IDLE;
            timer       <= '0;
            code_reg    <= '0;
            count       <= '0;
            b0_out      <= 1'b0;
            b1_out      <= 1'b0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            pass_out    <= 1'b0;
            hex_display <= SEG7_TABLE[0];
        end else begin
            done_out <= 1'b0;
            if (abort_req) begin
                state    <= ST_DONE;
                b0_out   <= 1'b0;
                b1_out   <= 1'b0;
                busy_out <= 1'b0;
                done_out <= 1'b1;
                pass_out <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_in) begin
                            state       <= ST_PRESS;
                            code_reg    <= code_in;
                            count       <= '0;
                            timer       <= '0;
                            pass_out    <= 1'b0;
                            busy_out    <= 1'b1;
                            hex_display <= SEG7_TABLE[0];
                            b1_out      <= code_in[CODE_LEN-1];
                            b0_out      <= ~code_in[CODE_LEN-1];
                        end
                    end
                    ST_PRESS: begin
                        if (timer == PRESS_LAST) begin
                            state       <= ST_GAP;
                            timer       <= '0;
                            b0_out      <= 1'b0;
                            b1_out      <= 1'b0;
                            count       <= count + 4'd1;
                            hex_display <= next_seg;
                            code_reg    <= code_reg << 1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (timer == GAP_LAST) begin
                            timer <= '0;
                            if (count == LEN) begin
                                state <= ST_WAIT_RESP;
                            end else begin
                                state  <= ST_PRESS;
                                b1_out <= code_reg[CODE_LEN-1];
                                b0_out <= ~code_reg[CODE_LEN-1];
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_WAIT_RESP: begin
                        if (unlock_in) begin
                            state    <= ST_DONE;
                            pass_out <= 1'b1;
                            done_out <= 1'b1;
                            busy_out <= 1'b0;
                        end else if (timer == TIMEOUT_LAST) begin
                            state    <= ST_DONE;
                            pass_out <= 1'b0;
                            done_out <= 1'b1;
                            busy_out <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
